// File: rtl/instruction_fetch_unit.sv
// RV32I fetch front end: owns the PC, issues one word fetch at a time and holds
// the returned instruction (plus a one-entry skid) for decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        fetch_valid,
  output logic [31:0] instruction_memory_data,
  output logic [31:0] program_counter,
  output logic        misaligned_fault
);

  // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // a response transfers on any cycle with imem_rsp_valid (no ready, one per request);
  // the output slot retires on a cycle where fetch_valid && !stall.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        fault_outstanding_q;
  logic        skid_valid_q;
  logic [31:0] skid_data_q;
  logic [31:0] skid_pc_q;

  logic req_fire;
  logic capture;
  logic consume;
  logic target_misaligned;
  logic outstanding;
  logic still_outstanding;

  assign imem_req_addr     = pc_q;
  assign imem_req_valid    = !rst && (state_q == S_REQ) && !skid_valid_q && !redirect_valid;
  assign req_fire          = imem_req_valid && imem_req_ready;
  assign capture           = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign consume           = fetch_valid && !stall;
  assign target_misaligned = |redirect_target[1:0];

  // A response still owed by memory must be swallowed before the next request.
  assign outstanding       = (state_q == S_WAIT) || (state_q == S_DRAIN) ||
                             ((state_q == S_FAULT) && fault_outstanding_q);
  assign still_outstanding = outstanding && !imem_rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= S_REQ;
      pc_q                <= RESET_VECTOR;
      req_pc_q            <= RESET_VECTOR;
      misaligned_fault    <= 1'b0;
      fault_outstanding_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q <= redirect_target;
      if (target_misaligned) begin
        misaligned_fault    <= 1'b1;
        fault_outstanding_q <= still_outstanding;
        state_q             <= S_FAULT;
      end else begin
        misaligned_fault    <= 1'b0;
        fault_outstanding_q <= 1'b0;
        state_q             <= still_outstanding ? S_DRAIN : S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) state_q <= S_REQ;
        end
        S_DRAIN: begin
          if (imem_rsp_valid) state_q <= S_REQ;
        end
        S_FAULT: begin
          if (imem_rsp_valid) fault_outstanding_q <= 1'b0;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  // Output slot and skid entry; the skid only fills while decode is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid             <= 1'b0;
      instruction_memory_data <= NOP_INSTRUCTION;
      program_counter         <= RESET_VECTOR;
      skid_valid_q            <= 1'b0;
      skid_data_q             <= NOP_INSTRUCTION;
      skid_pc_q               <= RESET_VECTOR;
    end else if (redirect_valid) begin
      fetch_valid             <= 1'b0;
      instruction_memory_data <= NOP_INSTRUCTION;
      skid_valid_q            <= 1'b0;
    end else if (consume && skid_valid_q) begin
      instruction_memory_data <= skid_data_q;
      program_counter         <= skid_pc_q;
      skid_valid_q            <= 1'b0;
    end else if (capture && (!fetch_valid || !stall)) begin
      fetch_valid             <= 1'b1;
      instruction_memory_data <= imem_rsp_data;
      program_counter         <= req_pc_q;
    end else if (capture) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= imem_rsp_data;
      skid_pc_q    <= req_pc_q;
    end else if (consume) begin
      fetch_valid             <= 1'b0;
      instruction_memory_data <= NOP_INSTRUCTION;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a queued memory model with
// programmable latency and hand-computed expected PCs and instruction words.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        fetch_valid;
  logic [31:0] instruction_memory_data;
  logic [31:0] program_counter;
  logic        misaligned_fault;

  int n_vec = 0;
  int n_err = 0;
  int lat = 1;
  int n_accept = 0;
  int cyc = 0;

  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];

  instruction_fetch_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .imem_req_valid          (imem_req_valid),
    .imem_req_ready          (imem_req_ready),
    .imem_req_addr           (imem_req_addr),
    .imem_rsp_valid          (imem_rsp_valid),
    .imem_rsp_data           (imem_rsp_data),
    .redirect_valid          (redirect_valid),
    .redirect_target         (redirect_target),
    .stall                   (stall),
    .fetch_valid             (fetch_valid),
    .instruction_memory_data (instruction_memory_data),
    .program_counter         (program_counter),
    .misaligned_fault        (misaligned_fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: two fixed words at 0x0/0x4, elsewhere {addr[23:0], 8'h13}.
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: word_at = 32'h0000_0093;
      32'h0000_0004: word_at = 32'h0010_0113;
      default:       word_at = {addr[23:0], 8'h13};
    endcase
  endfunction

  // Memory responder: in-order, one response per accepted request, lat >= 1.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      logic        acc;
      logic [31:0] acc_addr;
      @(posedge clk);
      acc      = imem_req_valid && imem_req_ready && !rst;
      acc_addr = imem_req_addr;
      cyc++;
      #1;
      imem_rsp_valid = 1'b0;
      if (rst) begin
        pend_addr_q.delete();
        pend_due_q.delete();
      end else begin
        if (acc) begin
          n_accept++;
          pend_addr_q.push_back(acc_addr);
          pend_due_q.push_back(cyc + lat - 1);
        end
        if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = word_at(pend_addr_q.pop_front());
          void'(pend_due_q.pop_front());
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] exp_pc, input logic [31:0] exp_data,
                              input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (fetch_valid) begin
        seen = 1'b1;
        check("fetch_pc", program_counter, exp_pc);
        check("fetch_data", instruction_memory_data, exp_data);
      end
    end
    if (!seen) check("fetch_timeout", {31'b0, fetch_valid}, 32'h1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid  = 1'b1;
    redirect_target = target;
    @(negedge clk);
    redirect_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    stall           = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_data", instruction_memory_data, NOP);
    check("rst_pc", program_counter, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_fault", {31'b0, misaligned_fault}, 32'h0);

    // 1-cycle memory, first two fetches and the 2-cycle accept-to-output latency
    rst = 1'b0;
    @(negedge clk);
    check("t1_wait_fv", {31'b0, fetch_valid}, 32'h0);
    check("t1_wait_req", {31'b0, imem_req_valid}, 32'h0);
    check("t1_pc_adv", imem_req_addr, 32'h4);
    @(negedge clk);
    check("t1_fv0", {31'b0, fetch_valid}, 32'h1);
    check("t1_pc0", program_counter, 32'h0);
    check("t1_data0", instruction_memory_data, 32'h0000_0093);
    @(negedge clk);
    check("t1_gap_fv", {31'b0, fetch_valid}, 32'h0);
    check("t1_gap_nop", instruction_memory_data, NOP);
    @(negedge clk);
    check("t1_fv1", {31'b0, fetch_valid}, 32'h1);
    check("t1_pc1", program_counter, 32'h4);
    check("t1_data1", instruction_memory_data, 32'h0010_0113);

    // stall for 4 cycles while 0x8 returns into the skid
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t2_skid_noreq", {31'b0, imem_req_valid}, 32'h0);
    check("t2_hold_pc", program_counter, 32'h4);
    check("t2_hold_data", instruction_memory_data, 32'h0010_0113);
    repeat (2) @(negedge clk);
    check("t2_hold_pc2", program_counter, 32'h4);
    check("t2_hold_fv", {31'b0, fetch_valid}, 32'h1);
    stall = 1'b0;
    expect_fetch(32'h8, 32'h0000_0813, 10);
    expect_fetch(32'hC, 32'h0000_0C13, 10);

    // redirect to 0x100 while a 3-cycle fetch of 0x8 is outstanding
    lat = 3;
    do_redirect(32'h8);
    check("t3_flush_fv", {31'b0, fetch_valid}, 32'h0);
    @(negedge clk);
    check("t3_wait_req", {31'b0, imem_req_valid}, 32'h0);
    check("t3_req_addr", imem_req_addr, 32'hC);
    do_redirect(32'h100);
    check("t3_redir_fv", {31'b0, fetch_valid}, 32'h0);
    check("t3_drain_req", {31'b0, imem_req_valid}, 32'h0);
    check("t3_redir_addr", imem_req_addr, 32'h100);
    expect_fetch(32'h100, 32'h0001_0013, 20);

    // misaligned redirect, then recovery
    lat = 1;
    do_redirect(32'h102);
    check("t4_fault_set", {31'b0, misaligned_fault}, 32'h1);
    check("t4_fault_fv", {31'b0, fetch_valid}, 32'h0);
    acc0 = n_accept;
    repeat (3) @(negedge clk);
    check("t4_fault_noreq", {31'b0, imem_req_valid}, 32'h0);
    check("t4_fault_nacc", n_accept, acc0);
    check("t4_fault_held", {31'b0, misaligned_fault}, 32'h1);
    do_redirect(32'h200);
    check("t4_fault_clr", {31'b0, misaligned_fault}, 32'h0);
    expect_fetch(32'h200, 32'h0002_0013, 10);

    // wrap from the top of the address space
    do_redirect(32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC, 32'hFFFF_FC13, 10);
    expect_fetch(32'h0, 32'h0000_0093, 10);
    expect_fetch(32'h4, 32'h0010_0113, 10);

    // async reset in the middle of WAIT with decode stalled
    lat   = 3;
    stall = 1'b1;
    @(negedge clk);
    check("t6_pre_pc", program_counter, 32'h4);
    check("t6_pre_req", {31'b0, imem_req_valid}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_fv", {31'b0, fetch_valid}, 32'h0);
    check("t6_rst_data", instruction_memory_data, NOP);
    check("t6_rst_pc", program_counter, 32'h0);
    check("t6_rst_req", {31'b0, imem_req_valid}, 32'h0);
    check("t6_rst_addr", imem_req_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    lat   = 1;
    expect_fetch(32'h0, 32'h0000_0093, 10);
    expect_fetch(32'h4, 32'h0010_0113, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the RV32I core: owns the program counter and issues word fetches to instruction memory over a valid/ready request and valid response handshake.
- Registers each returned instruction with its PC and presents the pair as instruction_memory_data/program_counter to decode and the immediate generator.
- Supports decode back-pressure (stall), branch/jump redirect with flush, and misaligned-target detection.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
NOP_INSTRUCTION, 32'h0000_0013, value driven on instruction_memory_data when slot is empty or flushed (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address (always pc_q)
imem_rsp_valid  input  1  response data valid (one cycle per accepted request, latency >= 1)
imem_rsp_data  input  32  fetched instruction word
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  32  new PC
stall  input  1  decode cannot accept output this cycle
fetch_valid  output  1  output slot holds a valid instruction
instruction_memory_data  output  32  instruction to decode
program_counter  output  32  PC of that instruction
misaligned_fault  output  1  sticky: last redirect target had bits[1:0] != 0

Behaviour:
- Reset (async, any state): pc_q = RESET_VECTOR; state = REQ; fetch_valid = 0; skid_valid = 0; instruction_memory_data = NOP_INSTRUCTION; program_counter = RESET_VECTOR; misaligned_fault = 0. imem_req_valid = 0 while rst is high. Any response in flight at reset is ignored.
- States: REQ, WAIT, DRAIN, FAULT. At most one outstanding request.
- REQ: imem_req_valid = !skid_valid && !redirect_valid. On valid&&ready: req_pc <= pc_q, pc_q <= pc_q + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), go to WAIT.
- WAIT: on imem_rsp_valid the word is tagged with req_pc.
  - Output slot free (!fetch_valid || !stall): load the output register and set fetch_valid.
  - Otherwise: load the one-entry skid buffer.
  - Then go to REQ.
- Consumption: fetch_valid && !stall retires the output.
  - If skid_valid: skid moves to the output and skid_valid clears.
  - Else if a response is captured in the same cycle: it loads the output.
  - Else: fetch_valid <= 0 and data <= NOP_INSTRUCTION.
- Latency: request accepted in cycle N with response in N+1 gives fetch_valid in N+2. Peak throughput is one instruction per 2 cycles at 1-cycle memory latency.
- Redirect has highest priority and applies in every state:
  - Clears fetch_valid and skid_valid; output data <= NOP_INSTRUCTION.
  - pc_q <= redirect_target.
  - Next state:
    - target[1:0] != 0: misaligned_fault <= 1, go to FAULT.
    - Currently in WAIT and no imem_rsp_valid this cycle: go to DRAIN.
    - Currently in WAIT with imem_rsp_valid this cycle: the response is discarded; go to REQ.
    - Otherwise: go to REQ.
  - An aligned redirect clears misaligned_fault.
- DRAIN: imem_req_valid = 0. The next imem_rsp_valid is discarded, then go to REQ. A further redirect in DRAIN updates pc_q and stays in DRAIN.
- FAULT: imem_req_valid = 0 and fetch_valid = 0; the state is held until a redirect or reset. An aligned redirect leaves FAULT per the rules above. If a request was outstanding on entry, the response is still discarded: FAULT tracks an outstanding flag and drains before the next REQ.
- stall has no effect on an empty slot. stall plus redirect in the same cycle: the flush wins.
- imem_req_addr = pc_q at all times. All outputs are registered except imem_req_valid and imem_req_addr.

Test Plan:
- Reset release, 1-cycle memory returning 32'h0000_0093 at 0x0 and 32'h0010_0113 at 0x4 -> fetch_valid rises 2 cycles after first accept; program_counter 0x0 then 0x4; instruction_memory_data matches.
- stall held 4 cycles while a response arrives -> word goes to skid, imem_req_valid = 0, output unchanged; after stall drops, PCs 0x8, 0xC appear in order with none lost or duplicated.
- Redirect to 0x100 while a 3-cycle-latency request to 0x8 is outstanding -> fetch_valid = 0 next cycle, stale response discarded, next fetch_valid shows program_counter = 0x100.
- Redirect to 0x102 -> misaligned_fault = 1, no requests issued; later redirect to 0x200 -> fault clears, fetch resumes at 0x200.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC, then 0x0000_0000.
- Async rst asserted mid-WAIT with stall = 1 -> outputs immediately reset values (NOP, RESET_VECTOR, fetch_valid = 0); fetch restarts at RESET_VECTOR.
